two_mux16: RTL and testbench
============================

TWO_MUX16 -- requirements
Module: two_mux16

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 W  input  16  data word; bit W[i] is candidate i.
REQ-005 S  input  4  select index, unsigned 0..15.
REQ-006 en  input  1  capture enable; 1 = sample W/S this cycle.
REQ-007 f  output  1  registered selected bit, W[S].
REQ-008 valid  output  1  high for one cycle when f carries a new result.

Function
REQ-009 The combinational select SHALL compute W[S] for all 16 values of S; there are no invalid select codes.
REQ-010 With en=1 at rising edge N, f SHALL equal W[S] sampled at edge N, visible after edge N (latency 1).
REQ-011 With en=1 at edge N, valid SHALL be 1 after edge N; otherwise valid SHALL be 0 after that edge.
REQ-012 With en=0, f SHALL hold its previous value regardless of W or S changes.
REQ-013 Back-to-back en=1 cycles SHALL produce one result per cycle with valid held high continuously.
REQ-014 Changes on W or S between edges SHALL NOT affect f; only values present at the sampling edge count.
REQ-015 S=4'hF SHALL select W[15]; S=4'h0 SHALL select W[0]; no wrap or saturation applies.
REQ-016 X/Z-free inputs SHALL yield an X-free f; no latches SHALL be inferred.

Reset
REQ-017 While rst_n=0, f SHALL be 0 and valid SHALL be 0, immediately and independent of clk.
REQ-018 Reset asserted mid-stream SHALL discard any in-flight result; the first en=1 edge after deassertion SHALL produce the first valid result with normal latency.
REQ-019 Deassertion SHALL be synchronous to clk at the system level; the block itself needs no synchronizer.

Configuration
REQ-020 Macro TWO_MUX16_INPUT_REG_EN, when defined, SHALL add an input register stage capturing W, S and en on every edge, giving latency 2 from en=1 to valid/f.
REQ-021 With TWO_MUX16_INPUT_REG_EN defined, the input stage SHALL reset to W=0, S=0, en=0 under rst_n=0.
REQ-022 Without the macro, latency SHALL be exactly 1 as in REQ-010; port list is identical in both builds.

Structure
REQ-023 Package two_mux16_pkg SHALL hold constants N_IN=16, SEL_W=4, GRP=4 and the reset values for f and valid.
REQ-024 The 16:1 select SHALL be built from one sub-module mux4 (4 data bits, 2-bit select, 1-bit out), instanced as four first-level muxes on S[1:0] and one second-level mux on S[3:2].
REQ-025 mux4 SHALL be purely combinational, with no clock or reset.

Verification
REQ-026 W=16'h3333, en=1, S stepped 0..15 one per cycle -> f sequence 1,1,0,0 repeated four times, each one cycle after its S; valid=1 throughout.
REQ-027 W=16'h8001, S=0 then S=15 then S=7 -> f=1,1,0.
REQ-028 W=16'hFFFF, S=5, en=1 then en=0 while W changes to 16'h0000 -> f stays 1 and valid drops to 0.
REQ-029 rst_n pulsed low mid-stream with f=1 -> f=0, valid=0 immediately; the next en=1 with W=16'h0004, S=2 -> f=1 after one edge.
REQ-030 TWO_MUX16_INPUT_REG_EN defined, W=16'h3333, S=2, single en pulse -> valid and f=0 appear two edges later; S=0 -> f=1 two edges later.
REQ-031 Random W/S for 1000 cycles with random en -> f matches the reference W[S] model at the configured latency whenever valid=1.

Source files
------------

// File: rtl/two_mux16_pkg.sv
// ============================================================================
// two_mux16_pkg : shared constants and types for the registered 16:1 bit mux
// Revision 1.0
// ============================================================================
`default_nettype none

package two_mux16_pkg;

  localparam int N_IN  = 16;  // candidate bits
  localparam int SEL_W = 4;   // select index width
  localparam int GRP   = 4;   // bits per first-level mux4

  localparam logic F_RST     = 1'b0;
  localparam logic VALID_RST = 1'b0;

  typedef logic [N_IN-1:0]  word_t;
  typedef logic [SEL_W-1:0] sel_t;

endpackage

`default_nettype wire

// File: rtl/two_mux16_mux4.sv
// ============================================================================
// mux4 : purely combinational 4:1 bit selector, leaf cell of two_mux16
// Revision 1.0
// ============================================================================
`default_nettype none

module mux4 (
  input  logic [3:0] d_i,
  input  logic [1:0] s_i,
  output logic       y_o
);

  assign y_o = d_i[s_i];

endmodule

`default_nettype wire

// File: rtl/two_mux16.sv
// ============================================================================
// two_mux16 : registered 16:1 bit select f = W[S] with a one-cycle valid strobe.
// Optional macro TWO_MUX16_INPUT_REG_EN adds an input register stage (latency 2).
// Revision 1.0
// ============================================================================
`default_nettype none

module two_mux16
  import two_mux16_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  W,
  input  logic [SEL_W-1:0] S,
  input  logic             en,
  output logic             f,
  output logic             valid
);

  word_t      word_s;
  sel_t       sel_s;
  logic       en_s;
  logic [3:0] lvl1;
  logic       mux_out;
  logic       f_q, f_d;
  logic       valid_q, valid_d;

`ifdef TWO_MUX16_INPUT_REG_EN
  word_t word_q;
  sel_t  sel_q;
  logic  en_q;

  // Input stage samples every edge; en is pipelined alongside its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      sel_q  <= '0;
      en_q   <= 1'b0;
    end else begin
      word_q <= W;
      sel_q  <= S;
      en_q   <= en;
    end
  end

  assign word_s = word_q;
  assign sel_s  = sel_q;
  assign en_s   = en_q;
`else
  assign word_s = W;
  assign sel_s  = S;
  assign en_s   = en;
`endif

  generate
    for (genvar g = 0; g < N_IN / GRP; g++) begin : g_lvl1
      mux4 u_mux4 (
        .d_i (word_s[GRP*g +: GRP]),
        .s_i (sel_s[1:0]),
        .y_o (lvl1[g])
      );
    end
  endgenerate

  mux4 u_mux4_lvl2 (
    .d_i (lvl1),
    .s_i (sel_s[3:2]),
    .y_o (mux_out)
  );

  always_comb begin
    f_d     = f_q;
    valid_d = en_s;
    if (en_s) begin
      f_d = mux_out;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= F_RST;
      valid_q <= VALID_RST;
    end else begin
      f_q     <= f_d;
      valid_q <= valid_d;
    end
  end

  assign f     = f_q;
  assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_two_mux16.sv
// ============================================================================
// tb_two_mux16 : self-checking bench for two_mux16 (either build of the macro)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_two_mux16;

`ifdef TWO_MUX16_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] W = '0;
  logic [3:0]  S = '0;
  logic        en = 1'b0;
  logic        f;
  logic        valid;

  int n_vec  = 0;
  int n_fail = 0;

  two_mux16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .W     (W),
    .S     (S),
    .en    (en),
    .f     (f),
    .valid (valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] w;
    logic [3:0]  s;
    logic        en;
    logic        f;
    logic        v;
  } vec_t;

  typedef struct {
    logic f;
    logic v;
  } exp_t;

  typedef struct {
    logic        en;
    logic [15:0] w;
    logic [3:0]  s;
  } smp_t;

  vec_t tbl[$];
  exp_t eq[$];
  smp_t mq[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [15:0] w, input logic [3:0] s, input logic e);
    W  = w;
    S  = s;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_f", f, 1'b0);
    check("reset_valid", valid, 1'b0);
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Single en pulse; result must appear exactly LAT edges later.
  task automatic pulse(input string name, input logic [15:0] w, input logic [3:0] s,
                       input logic exp_f);
    step(w, s, 1'b1);
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) step(16'h0000, 4'hA, 1'b0);
      check({name, "_valid"}, valid, (k == LAT));
      if (k >= LAT) check({name, "_f"}, f, exp_f);
    end
  endtask

  initial begin
    exp_t e;
    vec_t t;
    smp_t m;
    logic model_f;

    for (int i = 0; i < 16; i++)
      tbl.push_back('{16'h3333, 4'(i), 1'b1, ((i % 4) < 2), 1'b1});
    tbl.push_back('{16'h8001, 4'd0,  1'b1, 1'b1, 1'b1});
    tbl.push_back('{16'h8001, 4'd15, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{16'h8001, 4'd7,  1'b1, 1'b0, 1'b1});
    tbl.push_back('{16'hFFFF, 4'd5,  1'b1, 1'b1, 1'b1});
    tbl.push_back('{16'h0000, 4'd5,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{16'h0000, 4'd0,  1'b0, 1'b1, 1'b0});
    tbl.push_back('{16'hFFFF, 4'd15, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{16'h0000, 4'd15, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{16'h5555, 4'd1,  1'b0, 1'b0, 1'b0});
    tbl.push_back('{16'h5555, 4'd0,  1'b0, 1'b0, 1'b0});

    do_reset();

    // Table section: outputs after each edge belong to the record LAT-1 earlier.
    for (int i = 0; i < LAT - 1; i++) eq.push_back('{1'b0, 1'b0});
    foreach (tbl[i]) begin
      t = tbl[i];
      step(t.w, t.s, t.en);
      eq.push_back('{t.f, t.v});
      if (eq.size() == LAT) begin
        e = eq.pop_front();
        check($sformatf("tbl%0d_f", i), f, e.f);
        check($sformatf("tbl%0d_valid", i), valid, e.v);
      end
    end

    // Mid-cycle W/S churn after a capture must not disturb f.
    pulse("churn_cap", 16'h0010, 4'd4, 1'b1);
    for (int k = 0; k < 3; k++) begin
      W = 16'h0000; S = 4'(k);
      #2;
      W = 16'hFFEF; S = 4'd4;
      @(posedge clk);
      #1;
      check("churn_hold_f", f, 1'b1);
      check("churn_hold_valid", valid, 1'b0);
    end

    // Mid-stream reset with f=1, then normal restart.
    step(16'hFFFF, 4'd9, 1'b1);
    step(16'hFFFF, 4'd9, 1'b1);
    check("pre_rst_f", f, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_f", f, 1'b0);
    check("async_rst_valid", valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    step(16'h0000, 4'd0, 1'b0);
    check("post_rst_valid", valid, 1'b0);
    check("post_rst_f", f, 1'b0);
    pulse("rst_restart", 16'h0004, 4'd2, 1'b1);

    pulse("lat_s2", 16'h3333, 4'd2, 1'b0);
    pulse("lat_s0", 16'h3333, 4'd0, 1'b1);

    // Random section against a W[S] model delayed by LAT samples.
    do_reset();
    model_f = 1'b0;
    mq.delete();
    for (int i = 0; i < LAT - 1; i++) mq.push_back('{1'b0, 16'h0, 4'h0});
    for (int c = 0; c < 1000; c++) begin
      m.en = ($urandom_range(0, 2) != 0);
      m.w  = 16'($urandom);
      m.s  = 4'($urandom_range(0, 15));
      step(m.w, m.s, m.en);
      mq.push_back(m);
      if (mq.size() == LAT) begin
        m = mq.pop_front();
        if (m.en) model_f = (m.w >> m.s) & 16'h1;
        check("rand_valid", valid, m.en);
        check("rand_f", f, model_f);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
